// File: rtl/ocm_read_arbiter.sv
// Round-robin arbiter sharing one OCM burst-read master between two requesters.
// Define TXN_TIMEOUT_EN to enable the transaction watchdog and timeout_err.
module ocm_read_arbiter #(
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned IDX_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [IDX_W-1:0]  req0_index,
  output logic              req0_ready,
  output logic [DATA_W-1:0] req0_data,
  output logic              req0_data_valid,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic [IDX_W-1:0]  req1_index,
  output logic              req1_ready,
  output logic [DATA_W-1:0] req1_data,
  output logic              req1_data_valid,
  output logic              req1_done,
  output logic              init_master_txn,
  output logic [IDX_W-1:0]  read_addr_index,
  input  logic              read_active,
  input  logic              read_done,
  input  logic [DATA_W-1:0] ocm_data_out,
  input  logic              bus_data_valid,
  output logic              busy,
  output logic              grant_id,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_DONE, RELEASE
  } state_e;

  state_e            state_q;
  logic              last_q;
  logic              grant_q;
  logic              init_q;
  logic              tmo_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] d0_q;
  logic [DATA_W-1:0] d1_q;
  logic              v0_q;
  logic              v1_q;

  logic any_req;
  logic win;
  logic idle;
  logic in_txn;
  logic beat;
  logic tmo_hit;

  assign any_req = req0_valid | req1_valid;
  // On a tie the requester that was not granted last wins.
  assign win     = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign idle    = (state_q == IDLE);
  assign in_txn  = (state_q == ISSUE) | (state_q == WAIT_DONE);
  assign beat    = bus_data_valid & in_txn;

`ifdef TXN_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (idle) begin
      cnt_q <= '0;
    end else if (in_txn) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tmo_hit = in_txn & ~read_done &
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES[0];
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      init_q  <= 1'b0;
      tmo_q   <= 1'b0;
      idx_q   <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
    end else begin
      v0_q <= beat & ~grant_q;
      v1_q <= beat & grant_q;
      if (beat & ~grant_q) d0_q <= ocm_data_out;
      if (beat & grant_q)  d1_q <= ocm_data_out;
      if (tmo_hit) tmo_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            idx_q   <= win ? req1_index : req0_index;
            grant_q <= win;
            last_q  <= win;
            init_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (read_done | tmo_hit) begin
            init_q  <= 1'b0;
            state_q <= RELEASE;
          end else if (read_active) begin
            init_q  <= 1'b0;
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (read_done | tmo_hit) state_q <= RELEASE;
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready      = idle & any_req & ~win;
  assign req1_ready      = idle & any_req & win;
  assign req0_data       = d0_q;
  assign req1_data       = d1_q;
  assign req0_data_valid = v0_q;
  assign req1_data_valid = v1_q;
  assign req0_done       = (state_q == RELEASE) & ~grant_q;
  assign req1_done       = (state_q == RELEASE) & grant_q;
  assign init_master_txn = init_q;
  assign read_addr_index = idx_q;
  assign busy            = ~idle;
  assign grant_id        = grant_q;
  assign timeout_err     = tmo_q;

endmodule

// File: doc/ocm_read_arbiter.md
Name: ocm_read_arbiter

Overview:
- Shares the single OCM burst-read master between two requesters, e.g. two dfsm hash channels.
- Per-transaction round-robin grant; drives the master handshake (init_master_txn / read_active / read_done).
- Registers each returned 128-bit beat and steers it to the granted requester only.
- Sits between the dfsm instances and the AXI burst master logic in SHA3_BURST_MASTER.

Parameters:
- DATA_W, 128, width of ocm_data_out and the forwarded data.
- IDX_W, 32, width of read_addr_index and the request indices.
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles; used only with TXN_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 wants one read transaction; held until req0_ready.
- req0_index  in  IDX_W  read_addr_index for requester 0; stable while req0_valid.
- req0_ready  out  1  1-cycle pulse: request accepted, index latched.
- req0_data  out  DATA_W  registered beat for requester 0.
- req0_data_valid  out  1  1-cycle pulse: req0_data valid.
- req0_done  out  1  1-cycle pulse: requester 0 transaction finished.
- req1_valid, req1_index, req1_ready, req1_data, req1_data_valid, req1_done  as req0_*, for requester 1.
- init_master_txn  out  1  start request to the burst master.
- read_addr_index  out  IDX_W  latched index of the granted request.
- read_active  in  1  master transaction in progress.
- read_done  in  1  master transaction complete.
- ocm_data_out  in  DATA_W  read data from the master.
- bus_data_valid  in  1  ocm_data_out valid this cycle.
- busy  out  1  high in every state except IDLE.
- grant_id  out  1  requester currently or last granted.
- timeout_err  out  1  sticky watchdog flag; tied 0 without TXN_TIMEOUT_EN.

Behaviour:
- Reset values: all outputs 0, state IDLE. Internal last_grant=1, so req0 wins the first tie.
- Reset mid-transaction returns to IDLE immediately; no done pulse is issued.
- States: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE:
  - If any reqN_valid, pick the winner: the sole valid requester, or on a tie the one != last_grant.
  - Same cycle: pulse reqN_ready, latch reqN_index into read_addr_index, set grant_id and last_grant, go to ISSUE.
- ISSUE:
  - init_master_txn=1, held as a level.
  - read_active=1: drop init_master_txn next cycle, go to WAIT_DONE.
  - read_done=1 (with or without read_active): go directly to RELEASE.
- WAIT_DONE:
  - Hold until read_done=1, then go to RELEASE.
- Data beats:
  - Any cycle with bus_data_valid=1 in ISSUE or WAIT_DONE: ocm_data_out is registered into the granted reqN_data, and reqN_data_valid pulses on the next cycle.
  - Data latency is 1 cycle.
  - bus_data_valid in IDLE or RELEASE is ignored; no pulse.
  - The non-granted requester's data and valid never change.
- RELEASE (one cycle):
  - Pulse reqN_done. It coincides with the data_valid pulse of a beat that arrived on the read_done cycle.
  - Return to IDLE.
- Throughput: minimum gap between two grants is 3 cycles (grant → ISSUE → RELEASE → IDLE).
- A requester dropping valid before ready is legal; no grant results.
- reqN_ready fires only from IDLE. New requests wait while busy.
- Round robin strictly alternates under continuous contention; a lone requester is served back-to-back.

Optional Feature:
- Macro: TXN_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ISSUE and increments each cycle in ISSUE/WAIT_DONE.
  - Reaching TIMEOUT_CYCLES without read_done:
    - Force init_master_txn=0.
    - Set timeout_err=1; it is sticky until reset.
    - Go to RELEASE, which pulses reqN_done normally.
- Not defined: no counter; timeout_err constant 0; WAIT_DONE waits indefinitely.

Test Plan:
- Reset, then req0_valid=1 with index 0x10. Master raises read_active 3 cycles after init, then a beat "The quick brown " with read_done → req0_ready pulse; read_addr_index=0x10; init high until read_active; req0_data matches and req0_data_valid pulses together with req0_done; req1_* outputs remain 0.
- req0 and req1 valid in the same cycle (indices 0x0, 0x1), each transaction completing → req0 granted first, then req1 (grant_id 0 then 1); indices 0x0 then 0x1 presented on read_addr_index.
- Both requesters hold valid continuously for 6 transactions → grant_id sequence 0,1,0,1,0,1; each requester gets exactly 3 done pulses.
- read_done with a beat while still in ISSUE (read_active never seen) → a single data_valid pulse and done pulse; state back to IDLE; busy=0 three cycles after the grant.
- Assert reset while in WAIT_DONE → all outputs 0 on the following edge with no done pulse; a new req1 request after reset is served normally.
- With TXN_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, grant req1 and never assert read_done → after 16 cycles init=0, timeout_err=1, req1_done pulses, no data_valid; timeout_err stays 1 through later successful transactions.
